// File: rtl/seg_ctrl_pkg.sv
// Shared encodings for the segment-register write controller.
// Segment selects, requester indices and FSM states.
package seg_ctrl_pkg;

    localparam logic [1:0] SEG_CS = 2'b00;
    localparam logic [1:0] SEG_DS = 2'b01;
    localparam logic [1:0] SEG_SS = 2'b10;
    localparam logic [1:0] SEG_ES = 2'b11;

    localparam int EU  = 0;
    localparam int BR  = 1;
    localparam int INT = 2;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FLUSH
    } state_t;

endpackage

// File: rtl/seg_prio_arb.sv
// Fixed-priority arbiter (int > br > eu) for the segment write port.
// A saturating loss counter promotes eu once it has lost STARVE_LIMIT times.
module seg_prio_arb
    import seg_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       idle,
    input  logic       wr,
    input  logic       eu_won,
    output logic [2:0] win,
    output logic       valid
);

    logic [2:0] starve_cnt;
    logic       promote;

    assign promote = req[EU] && (starve_cnt == 3'(STARVE_LIMIT));
    assign valid   = |win;

    // Pick one winner; a starved eu overrides the fixed order.
    always_comb begin
        win = '0;
        if (promote) begin
            win[EU] = 1'b1;
        end else if (req[INT]) begin
            win[INT] = 1'b1;
        end else if (req[BR]) begin
            win[BR] = 1'b1;
        end else if (req[EU]) begin
            win[EU] = 1'b1;
        end
    end

    // Count eu losses per write; clear on eu grant or when eu is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (wr) begin
            if (eu_won) begin
                starve_cnt <= '0;
            end else if (req[EU] && starve_cnt != 3'd7) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end else if (idle && !req[EU]) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/seg_write_ctrl.sv
// Owner of the CS/DS/SS/ES write port: arbitration, CS flush, SS inhibit.
// Optional shadow copies of the bank are built when SEG_SHADOW_EN is defined.
module seg_write_ctrl
    import seg_ctrl_pkg::*;
#(
    parameter int SEG_W        = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             eu_req,
    input  logic [1:0]       eu_sel,
    input  logic [SEG_W-1:0] eu_data,
    output logic             eu_gnt,
    input  logic             br_req,
    input  logic [SEG_W-1:0] br_data,
    output logic             br_gnt,
    input  logic             int_req,
    input  logic [SEG_W-1:0] int_data,
    output logic             int_gnt,
    input  logic             instr_done,
    output logic             seg_we,
    output logic [1:0]       seg_sel,
    output logic [SEG_W-1:0] seg_data,
    output logic             flush,
    output logic             busy,
    output logic             irq_inhibit,
    input  logic [1:0]       shad_sel,
    output logic [SEG_W-1:0] shad_data
);

    state_t           state;
    state_t           state_nx;
    logic [3:0]       fl_cnt;
    logic [1:0]       inh_cnt;
    logic [1:0]       inh_nx;
    logic [2:0]       win;
    logic             win_vld;
    logic             grant;
    logic [1:0]       nx_sel;
    logic [SEG_W-1:0] nx_data;

    seg_prio_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({int_req, br_req, eu_req}),
        .idle   (state == IDLE),
        .wr     (state == WRITE),
        .eu_won (eu_gnt),
        .win    (win),
        .valid  (win_vld)
    );

    assign grant = (state == IDLE) && win_vld;

    // Route the winner's target and value; far branch and vector load hit CS.
    always_comb begin
        nx_sel  = eu_sel;
        nx_data = eu_data;
        unique case (1'b1)
            win[INT]: begin
                nx_sel  = SEG_CS;
                nx_data = int_data;
            end
            win[BR]: begin
                nx_sel  = SEG_CS;
                nx_data = br_data;
            end
            default: ;
        endcase
    end

    // Next state: one write cycle, then a flush window only after CS.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (grant) state_nx = WRITE;
            WRITE:   state_nx = (seg_sel == SEG_CS) ? FLUSH : IDLE;
            FLUSH:   if (fl_cnt == 4'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Flush window length; reloaded on every write so each CS write gets a full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fl_cnt <= '0;
        end else if (state == WRITE) begin
            fl_cnt <= 4'(FLUSH_CYCLES - 1);
        end else if (state == FLUSH && fl_cnt != 4'd0) begin
            fl_cnt <= fl_cnt - 4'd1;
        end
    end

    // Registered bank controls and grants, derived from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_we   <= 1'b0;
            seg_sel  <= '0;
            seg_data <= '0;
            eu_gnt   <= 1'b0;
            br_gnt   <= 1'b0;
            int_gnt  <= 1'b0;
            flush    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            seg_we  <= (state_nx == WRITE);
            flush   <= (state_nx == FLUSH);
            busy    <= (state_nx != IDLE);
            eu_gnt  <= grant && win[EU];
            br_gnt  <= grant && win[BR];
            int_gnt <= grant && win[INT];
            if (grant) begin
                seg_sel  <= nx_sel;
                seg_data <= nx_data;
            end
        end
    end

    // SS write arms a two-retire inhibit; a reload beats a same-cycle retire.
    always_comb begin
        inh_nx = inh_cnt;
        if (state == WRITE && seg_sel == SEG_SS) begin
            inh_nx = 2'd2;
        end else if (instr_done && inh_cnt != 2'd0) begin
            inh_nx = inh_cnt - 2'd1;
        end
    end

    // Inhibit counter and its registered flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inh_cnt     <= '0;
            irq_inhibit <= 1'b0;
        end else begin
            inh_cnt     <= inh_nx;
            irq_inhibit <= (inh_nx != 2'd0);
        end
    end

`ifdef SEG_SHADOW_EN
    logic [SEG_W-1:0] shadow [4];

    // Mirror every bank write so software-visible state can be read back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
            end
        end else if (seg_we) begin
            shadow[seg_sel] <= seg_data;
        end
    end

    assign shad_data = shadow[shad_sel];
`else
    logic shad_unused;

    assign shad_unused = ^shad_sel;
    assign shad_data   = '0;
`endif

endmodule

// File: tb/tb_seg_write_ctrl.sv
// Bench for seg_write_ctrl: vector table, directed corner sequences,
// and randomized traffic against a schedule-queue reference model.
module tb_seg_write_ctrl;

    localparam int FC = 2;
    localparam int SL = 3;
`ifdef SEG_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       eu_req = 0, br_req = 0, int_req = 0, instr_done = 0;
    logic [1:0] eu_sel = 0, shad_sel = 0;
    logic [7:0] eu_data = 0, br_data = 0, int_data = 0;
    logic       eu_gnt, br_gnt, int_gnt, seg_we, flush, busy, irq_inhibit;
    logic [1:0] seg_sel;
    logic [7:0] seg_data, shad_data;

    int n_chk = 0;
    int n_fail = 0;

    seg_write_ctrl dut (
        .clk(clk), .rst(rst),
        .eu_req(eu_req), .eu_sel(eu_sel), .eu_data(eu_data), .eu_gnt(eu_gnt),
        .br_req(br_req), .br_data(br_data), .br_gnt(br_gnt),
        .int_req(int_req), .int_data(int_data), .int_gnt(int_gnt),
        .instr_done(instr_done),
        .seg_we(seg_we), .seg_sel(seg_sel), .seg_data(seg_data),
        .flush(flush), .busy(busy), .irq_inhibit(irq_inhibit),
        .shad_sel(shad_sel), .shad_data(shad_data)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        chk("wait_idle", 64'(busy), 64'd0);
    endtask

    // Called in a write cycle; counts flush cycles until idle.
    task automatic count_flush(output int n);
        int k = 0;
        n = 0;
        tick();
        while (busy && k < 40) begin
            if (flush) n++;
            tick();
            k++;
        end
    endtask

    task automatic wait_gnt(output logic [2:0] g);
        int k = 0;
        g = '0;
        while (k < 40) begin
            tick();
            k++;
            g = {int_gnt, br_gnt, eu_gnt};
            if (g != 3'b000) break;
        end
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
        int         fl;
        logic       inh;
    } vec_t;

    typedef struct packed {
        logic       we;
        logic [1:0] sel;
        logic [7:0] data;
        logic [2:0] gnt;
        logic       fl;
    } rec_t;

    vec_t       tv[4];
    rec_t       q[$];
    rec_t       cur, r;
    logic [2:0] w, pg, g;
    int         m_starve, m_inh, n;
    logic [7:0] m_shad[4];

    initial begin
        tv[0] = '{2'b01, 8'h3C, 0, 1'b0};
        tv[1] = '{2'b11, 8'h5A, 0, 1'b0};
        tv[2] = '{2'b00, 8'h77, FC, 1'b0};
        tv[3] = '{2'b10, 8'h55, 0, 1'b1};

        #12;
        chk("reset_outs",
            64'({seg_we, seg_sel, seg_data, eu_gnt, br_gnt, int_gnt,
                 flush, busy, irq_inhibit, shad_data}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            eu_req  = 1'b1;
            eu_sel  = tv[i].sel;
            eu_data = tv[i].data;
            tick();
            chk("tv_write",
                64'({eu_gnt, br_gnt, int_gnt, seg_we, seg_sel, seg_data}),
                64'({3'b100, 1'b1, tv[i].sel, tv[i].data}));
            eu_req = 1'b0;
            count_flush(n);
            chk("tv_flush_len", 64'(n), 64'(tv[i].fl));
            chk("tv_inhibit", 64'(irq_inhibit), 64'(tv[i].inh));
            pulse_done();
            pulse_done();
        end

        int_req = 1'b1; int_data = 8'hA0;
        br_req  = 1'b1; br_data  = 8'hB5;
        tick();
        chk("ib_int_first",
            64'({int_gnt, br_gnt, eu_gnt, seg_we, seg_sel, seg_data}),
            64'({3'b100, 1'b1, 2'b00, 8'hA0}));
        int_req = 1'b0;
        count_flush(n);
        chk("ib_flush1", 64'(n), 64'(FC));
        tick();
        chk("ib_br_second",
            64'({int_gnt, br_gnt, eu_gnt, seg_we, seg_sel, seg_data}),
            64'({3'b010, 1'b1, 2'b00, 8'hB5}));
        br_req = 1'b0;
        count_flush(n);
        chk("ib_flush2", 64'(n), 64'(FC));

        eu_req = 1'b1; eu_sel = 2'b01; eu_data = 8'h44;
        int_req = 1'b1; br_req = 1'b1;
        for (int i = 0; i < SL; i++) begin
            wait_gnt(g);
            chk("starve_loss", 64'(g), 64'(3'b100));
        end
        wait_gnt(g);
        chk("starve_eu_win", 64'({g, seg_sel, seg_data}),
            64'({3'b001, 2'b01, 8'h44}));
        wait_gnt(g);
        chk("starve_cleared", 64'(g), 64'(3'b100));
        int_req = 1'b0;
        wait_gnt(g);
        chk("starve_br", 64'(g), 64'(3'b010));
        br_req = 1'b0;
        wait_gnt(g);
        chk("starve_eu_tail", 64'(g), 64'(3'b001));
        eu_req = 1'b0;
        wait_idle();

        eu_req = 1'b1; eu_sel = 2'b10; eu_data = 8'h55;
        tick();
        chk("ss_write", 64'({seg_we, seg_sel, seg_data, irq_inhibit}),
            64'({1'b1, 2'b10, 8'h55, 1'b0}));
        eu_req = 1'b0;
        tick();
        chk("ss_inh_on", 64'(irq_inhibit), 64'd1);
        pulse_done();
        chk("ss_after_1", 64'(irq_inhibit), 64'd1);
        pulse_done();
        chk("ss_after_2", 64'(irq_inhibit), 64'd0);
        eu_req = 1'b1; eu_data = 8'h66;
        tick();
        eu_req = 1'b0;
        tick();
        pulse_done();
        chk("ss2_after_1", 64'(irq_inhibit), 64'd1);
        eu_req = 1'b1; eu_data = 8'h67;
        tick();
        instr_done = 1'b1; eu_req = 1'b0;
        tick();
        instr_done = 1'b0;
        chk("ss_reload", 64'(irq_inhibit), 64'd1);
        pulse_done();
        chk("ss_reload_1", 64'(irq_inhibit), 64'd1);
        pulse_done();
        chk("ss_reload_2", 64'(irq_inhibit), 64'd0);

        eu_req = 1'b1; eu_sel = 2'b01; eu_data = 8'h11;
        tick();
        eu_req = 1'b0;
        tick();
        eu_req = 1'b1; eu_sel = 2'b11; eu_data = 8'h22;
        tick();
        eu_req = 1'b0;
        tick();
        shad_sel = 2'b01;
        #1;
        chk("shadow_ds", 64'(shad_data), 64'(SHADOW ? 8'h11 : 8'h00));
        shad_sel = 2'b11;
        #1;
        chk("shadow_es", 64'(shad_data), 64'(SHADOW ? 8'h22 : 8'h00));

        tick();
        eu_req = 1'b1; eu_sel = 2'b10; eu_data = 8'h99;
        tick();
        eu_req = 1'b0;
        tick();
        eu_req = 1'b1; eu_sel = 2'b00; eu_data = 8'h42;
        tick();
        eu_req = 1'b0;
        tick();
        chk("pre_reset", 64'({flush, busy, irq_inhibit}), 64'(3'b111));
        #2 rst = 1'b1;
        #1;
        chk("async_reset",
            64'({flush, busy, seg_we, irq_inhibit, eu_gnt, shad_data}),
            64'd0);
        #2 rst = 1'b0;
        tick();
        chk("post_reset", 64'({flush, busy, seg_we, irq_inhibit}), 64'd0);
        eu_req = 1'b1; eu_sel = 2'b01; eu_data = 8'h5E;
        tick();
        chk("post_reset_idle", 64'({seg_we, eu_gnt, seg_sel, seg_data}),
            64'({2'b11, 2'b01, 8'h5E}));
        eu_req = 1'b0;
        tick();

        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        cur = '0;
        pg = '0;
        m_starve = 0;
        m_inh = 0;
        for (int i = 0; i < 4; i++) m_shad[i] = '0;
        for (int c = 0; c < 1500; c++) begin
            chk("rnd_ctrl",
                64'({seg_we, int_gnt, br_gnt, eu_gnt, flush, busy,
                     irq_inhibit}),
                64'({cur.we, cur.gnt, cur.fl, cur.we | cur.fl,
                     m_inh != 0}));
            if (cur.we)
                chk("rnd_data", 64'({seg_sel, seg_data}),
                    64'({cur.sel, cur.data}));
            chk("rnd_shadow", 64'(shad_data),
                64'(SHADOW ? m_shad[shad_sel] : 8'h00));

            if (pg[0] || !eu_req) begin
                eu_req  = ($urandom_range(0, 1) == 1);
                eu_sel  = 2'($urandom_range(0, 3));
                eu_data = 8'($urandom);
            end
            if (pg[1] || !br_req) begin
                br_req  = ($urandom_range(0, 5) == 0);
                br_data = 8'($urandom);
            end
            if (pg[2] || !int_req) begin
                int_req  = ($urandom_range(0, 5) == 0);
                int_data = 8'($urandom);
            end
            instr_done = ($urandom_range(0, 2) == 0);
            shad_sel   = 2'($urandom_range(0, 3));
            pg = cur.gnt;

            if (!(cur.we || cur.fl)) begin
                w = 3'b000;
                if (m_starve == SL && eu_req) w = 3'b001;
                else if (int_req) w = 3'b100;
                else if (br_req) w = 3'b010;
                else if (eu_req) w = 3'b001;
                if (w != 3'b000) begin
                    r = '0;
                    r.we = 1'b1;
                    r.gnt = w;
                    r.sel = w[0] ? eu_sel : 2'b00;
                    r.data = w[2] ? int_data : (w[1] ? br_data : eu_data);
                    q.push_back(r);
                    if (r.sel == 2'b00) begin
                        r = '0;
                        r.fl = 1'b1;
                        repeat (FC) q.push_back(r);
                    end
                end
                if (!eu_req) m_starve = 0;
            end else if (cur.we) begin
                if (cur.gnt[0]) m_starve = 0;
                else if (eu_req && m_starve < 7) m_starve++;
            end
            if (cur.we && cur.sel == 2'b10) m_inh = 2;
            else if (instr_done && m_inh > 0) m_inh--;
            if (cur.we) m_shad[cur.sel] = cur.data;
            cur = (q.size() > 0) ? q.pop_front() : '0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
